reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 27 ++
 rtl/sync_ff.sv | 27 ++
 rtl/reset_sequencer.sv | 171 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, status-counter width and small helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT,
    HOLD,
    RELEASE,
    RUN,
    PLL_RESET
  } state_t;

  // Width of the saturating status counters.
  localparam int SAT_W = 8;

  // Bits needed to hold 0..max_val.
  // Never returns 0, so one-value counters still get a real register.
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (v == {SAT_W{1'b1}}) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing WIDTH asynchronous bits into the clk domain.
// Latency: STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rstn (sync active-low, clears the chain to 0), d (async in), q (synchronised out).
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stg <= '0;
    end else begin
      stg <= {stg[STAGES-2:0], d};
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises button/lock flags, then releases domain resets in staged order.
// Latency: SYNC_STAGES cycles input to decision, plus one registered output cycle.
// Backpressure: none; free-running control block without handshakes.
// Ports: clk/rstn (sync active-low), ext_rstn (async button), locked (async lock flags),
//   soft_rst_req (1-cycle pulse), rst_out (active-high per domain), pll_rst, ready,
//   lock_loss_cnt/timeout_cnt (saturating status).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_LOCKS        = 2,
  parameter int N_DOMAINS      = 3,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGE_GAP      = 4,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ext_rstn,
  input  logic [N_LOCKS-1:0]   locked,
  input  logic                 soft_rst_req,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 pll_rst,
  output logic                 ready,
  output logic [SAT_W-1:0]     lock_loss_cnt,
  output logic [SAT_W-1:0]     timeout_cnt
);

  localparam int WW = width_for(LOCK_TIMEOUT - 1);
  localparam int HW = width_for(HOLD_CYCLES - 1);
  localparam int GW = width_for(STAGE_GAP - 1);
  localparam int PW = width_for(PLL_RST_CYCLES - 1);

  localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [PW-1:0] PLL_LAST  = PW'(PLL_RST_CYCLES - 1);

  // rst_out always has the shape 1..10..0: releasing the next domain is a
  // left shift with zero fill, and the all-zero result means every domain is out.
  localparam logic [N_DOMAINS-1:0] FIRST_REL = {N_DOMAINS{1'b1}} << 1;

  logic [N_LOCKS:0]     sync_q;
  logic                 ext_rstn_s;
  logic [N_LOCKS-1:0]   locked_s;
  logic                 all_locked;
  logic                 ok;
  logic [N_DOMAINS-1:0] rst_shift;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] pll_cnt;

  sync_ff #(
    .WIDTH (N_LOCKS + 1),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   ({ext_rstn, locked}),
    .q   (sync_q)
  );

  assign ext_rstn_s = sync_q[N_LOCKS];
  assign locked_s   = sync_q[N_LOCKS-1:0];
  assign all_locked = &locked_s;
  assign ok         = all_locked & ext_rstn_s;
  assign rst_shift  = rst_out << 1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ASSERT;
      rst_out       <= '1;
      pll_rst       <= 1'b0;
      ready         <= 1'b0;
      wait_cnt      <= '0;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      pll_cnt       <= '0;
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      case (state)
        ASSERT: begin
          rst_out <= '1;
          ready   <= 1'b0;
          pll_rst <= 1'b0;
          if (ok) begin
            state    <= HOLD;
            hold_cnt <= '0;
            wait_cnt <= '0;
          end else if (!ext_rstn_s) begin
            // Lock timeout only runs while the button is released.
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= PLL_RESET;
            pll_rst     <= 1'b1;
            pll_cnt     <= '0;
            wait_cnt    <= '0;
            timeout_cnt <= sat_inc(timeout_cnt);
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        HOLD: begin
          if (!ok) begin
            // Lock loss before any release is not counted.
            state <= ASSERT;
          end else if (hold_cnt == HOLD_LAST) begin
            rst_out <= FIRST_REL;
            gap_cnt <= '0;
            if (FIRST_REL == '0) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        RELEASE, RUN: begin
          if (!all_locked || !ext_rstn_s || soft_rst_req) begin
            // One abort regardless of how many causes coincide.
            state   <= ASSERT;
            rst_out <= '1;
            ready   <= 1'b0;
            if (!all_locked) begin
              lock_loss_cnt <= sat_inc(lock_loss_cnt);
            end
          end else if (state == RELEASE) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              rst_out <= rst_shift;
              if (rst_shift == '0) begin
                state <= RUN;
                ready <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end

        PLL_RESET: begin
          // Lock flags, button and soft requests are all ignored during the pulse.
          rst_out <= '1;
          if (pll_cnt == PLL_LAST) begin
            pll_rst <= 1'b0;
            state   <= ASSERT;
          end else begin
            pll_cnt <= pll_cnt + PW'(1);
          end
        end

        default: begin
          state   <= ASSERT;
          rst_out <= '1;
          ready   <= 1'b0;
          pll_rst <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed + random stimulus against a timestamp-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reset_sequencer;

  localparam int N_LOCKS        = 2;
  localparam int N_DOMAINS      = 3;
  localparam int HOLD_CYCLES    = 8;
  localparam int STAGE_GAP      = 4;
  localparam int LOCK_TIMEOUT   = 20;
  localparam int PLL_RST_CYCLES = 16;
  localparam int SYNC_STAGES    = 2;

  logic                 clk;
  logic                 rstn;
  logic                 ext_rstn;
  logic [N_LOCKS-1:0]   locked;
  logic                 soft_rst_req;
  logic [N_DOMAINS-1:0] rst_out;
  logic                 pll_rst;
  logic                 ready;
  logic [7:0]           lock_loss_cnt;
  logic [7:0]           timeout_cnt;

  int n_vec;
  int n_err;

  reset_sequencer #(
    .N_LOCKS       (N_LOCKS),
    .N_DOMAINS     (N_DOMAINS),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .STAGE_GAP     (STAGE_GAP),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ext_rstn     (ext_rstn),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .rst_out      (rst_out),
    .pll_rst      (pll_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. The release schedule is a function of the number of
  // edges since good inputs were first seen (m_t); no state machine.
  logic [N_LOCKS:0] sh [SYNC_STAGES];  // sh[0] newest sample of {ext_rstn, locked}
  bit m_seq;    // a release sequence is under way
  int m_t;      // edges since the sequence started
  int m_pll;    // remaining pll_rst cycles
  int m_wait;   // consecutive unlocked edges with the button released
  int m_ll;
  int m_to;

  task automatic model_edge();
    logic               ext_s;
    logic [N_LOCKS-1:0] lk_s;
    bit                 in_rel;
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sh[s] = '0;
      m_seq = 0; m_t = 0; m_pll = 0; m_wait = 0; m_ll = 0; m_to = 0;
      return;
    end
    {ext_s, lk_s} = sh[SYNC_STAGES-1];
    if (m_pll > 0) begin
      m_pll--;
    end else if (m_seq) begin
      in_rel = (m_t >= HOLD_CYCLES);
      if (!(&lk_s) || !ext_s || (soft_rst_req && in_rel)) begin
        if (!(&lk_s) && in_rel && m_ll < 255) m_ll++;
        m_seq  = 0;
        m_wait = 0;
      end else begin
        m_t++;
      end
    end else if (ext_s && (&lk_s)) begin
      m_seq  = 1;
      m_t    = 0;
      m_wait = 0;
    end else if (ext_s) begin
      m_wait++;
      if (m_wait == LOCK_TIMEOUT) begin
        m_pll  = PLL_RST_CYCLES;
        m_wait = 0;
        if (m_to < 255) m_to++;
      end
    end else begin
      m_wait = 0;
    end
    for (int s = SYNC_STAGES - 1; s > 0; s--) sh[s] = sh[s-1];
    sh[0] = {ext_rstn, locked};
  endtask

  function automatic logic [N_DOMAINS-1:0] exp_rst();
    logic [N_DOMAINS-1:0] r;
    r = '1;
    if (m_seq)
      for (int i = 0; i < N_DOMAINS; i++) r[i] = (m_t < HOLD_CYCLES + STAGE_GAP * i);
    return r;
  endfunction

  function automatic logic exp_ready();
    return m_seq && (m_t >= HOLD_CYCLES + STAGE_GAP * (N_DOMAINS - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rst_out", 32'(rst_out), 32'(exp_rst()));
    chk("pll_rst", 32'(pll_rst), 32'(m_pll > 0));
    chk("ready", 32'(ready), 32'(exp_ready()));
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_ll));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
  endtask

  initial begin
    int ll_before;
    int hold_left;
    int r;
    n_vec = 0;
    n_err = 0;
    hold_left = 0;

    // Reset, then release with good inputs: ok_s rises at edge 2,
    // rst_out[0] falls at 11, [1] at 15, [2] and ready at 19.
    rstn = 1'b0; ext_rstn = 1'b1; locked = '1; soft_rst_req = 1'b0;
    repeat (3) step();
    chk("reset_rst_out", 32'(rst_out), 32'h7);
    rstn = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 10) chk("rel0_before", 32'(rst_out), 32'h7);
      if (i == 11) chk("rel0_edge", 32'(rst_out), 32'h6);
      if (i == 14) chk("rel1_before", 32'(rst_out), 32'h6);
      if (i == 15) chk("rel1_edge", 32'(rst_out), 32'h4);
      if (i == 18) chk("ready_before", 32'(ready), 32'h0);
      if (i == 19) chk("rel2_ready", 32'({ready, rst_out}), 32'h8);
    end

    // One-cycle lock loss in RUN: abort two edges later, counter to 1.
    locked = 2'b01; step();
    locked = '1; step(); step();
    chk("ll_abort_rst", 32'(rst_out), 32'h7);
    chk("ll_abort_cnt", 32'(lock_loss_cnt), 32'd1);
    repeat (30) step();
    chk("ll_rerelease", 32'(ready), 32'h1);

    // Lock glitch while holding at hold_cnt=5: back to ASSERT, not counted.
    locked = '0; step();
    locked = '1;
    for (int k = 0; k < 60 && !(m_seq && m_t == 3); k++) step();
    chk("hold_reached", 32'(m_seq && m_t == 3), 32'h1);
    ll_before = m_ll;
    locked = 2'b10; step();
    locked = '1; step(); step();
    chk("hold_abort_rst", 32'(rst_out), 32'h7);
    chk("hold_abort_ll", 32'(lock_loss_cnt), 32'(ll_before));
    repeat (30) step();

    // Soft request and lock loss on the same edge: one abort, one count.
    ll_before = m_ll;
    locked = 2'b10; step(); step();
    soft_rst_req = 1'b1; step();
    soft_rst_req = 1'b0;
    chk("soft_ll_cnt", 32'(lock_loss_cnt), 32'(ll_before + 1));
    soft_rst_req = 1'b1; step();
    soft_rst_req = 1'b0;
    chk("soft_in_assert", 32'(rst_out), 32'h7);
    locked = '1;
    repeat (30) step();

    // Random disturbances.
    for (int c = 0; c < 2000; c++) begin
      if (hold_left == 0) begin
        r = $urandom_range(0, 99);
        if (r < 4) begin
          locked = N_LOCKS'($urandom_range(0, 2));
          hold_left = $urandom_range(1, 30);
        end else if (r < 6) begin
          ext_rstn = 1'b0;
          hold_left = $urandom_range(1, 5);
        end else begin
          locked = '1;
          ext_rstn = 1'b1;
        end
      end else begin
        hold_left--;
      end
      soft_rst_req = ($urandom_range(0, 39) == 0);
      step();
    end

    // 300 counted lock losses saturate the counter.
    ext_rstn = 1'b1; soft_rst_req = 1'b0; locked = '1;
    repeat (40) step();
    for (int k = 0; k < 300; k++) begin
      locked = '0; step();
      locked = '1;
      repeat (13) step();
    end
    chk("ll_saturated", 32'(lock_loss_cnt), 32'd255);

    // Lock timeout: pll_rst 20 edges after ext_rstn_s rises, 16 wide, repeating.
    rstn = 1'b0; ext_rstn = 1'b0; locked = '0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (3) step();
    ext_rstn = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 21) chk("to_before", 32'(pll_rst), 32'h0);
      if (k == 22) chk("to_rise", 32'({timeout_cnt, pll_rst}), 32'h3);
      if (k == 37) chk("to_last", 32'(pll_rst), 32'h1);
      if (k == 38) chk("to_fall", 32'({pll_rst, rst_out}), 32'h7);
      if (k == 58) chk("to_second", 32'({timeout_cnt, pll_rst}), 32'h5);
    end
    rstn = 1'b0; step();
    chk("rst_mid_pll", 32'({lock_loss_cnt, timeout_cnt, pll_rst}), 32'h0);
    rstn = 1'b1; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
